rv32_mem_stage: RTL and testbench

Memory (MEM) stage of the five-stage RV32 pipeline: consumes the EX/MEM register (`ex_mem_t`), performs loads and stores over a request/ready/rvalid data-memory port, and produces the registered MEM/WB record (`mem_wb_t`). Non-memory instructions pass through with one cycle of latency. Memory instructions stall the upstream pipeline until the access completes. Sub-word loads are sign- or zero-extended by funct3.

---
 rtl/rv32_mem_stage.sv | 180 ++++++++++++++++++
 tb/tb_rv32_mem_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_stage.sv
// MEM stage of the RV32 pipeline: loads/stores over a req/ready/rvalid port, registered MEM/WB out.
// Optional RV32_MEM_MISALIGN_TRAP_EN: misaligned accesses become a bubble plus a misalign_o pulse.
package rv32_pipeline_pkg;
   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] alu_result;
      logic [31:0] mem_store_value;
      logic [4:0]  rd;
      logic        regFile_we;
      logic        mem_read_en;
      logic        mem_write_en;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] reg_store_value;
      logic [4:0]  rd;
      logic        regFile_we;
   } mem_wb_t;

   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
   localparam mem_wb_t     MEM_WB_BUBBLE = '{instruction: NOP_INSTR, reg_store_value: '0,
                                             rd: '0, regFile_we: 1'b0};
endpackage

module rv32_mem_stage
   import rv32_pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  ex_mem_t     ex_mem_i,
   input  logic        ex_mem_valid_i,
   output logic        stall_o,
   output mem_wb_t     mem_wb_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ready_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        misalign_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   mem_wb_t     mem_wb_q, mem_wb_d;

   logic [2:0]  funct3;
   logic [1:0]  lane;
   logic        is_mem, is_store, is_load;
   logic        size_b, size_h;
   logic        misaligned;
   logic        req, complete;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   always_comb begin
      funct3   = ex_mem_i.instruction[14:12];
      lane     = ex_mem_i.alu_result[1:0];
      is_mem   = ex_mem_valid_i & (ex_mem_i.mem_read_en | ex_mem_i.mem_write_en);
      is_store = is_mem & ex_mem_i.mem_write_en;
      is_load  = is_mem & ~ex_mem_i.mem_write_en;
      // Unsigned encodings only exist for loads; any other funct3 falls back to word size.
      size_b   = (funct3 == 3'b000) | (is_load & (funct3 == 3'b100));
      size_h   = (funct3 == 3'b001) | (is_load & (funct3 == 3'b101));
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      misaligned = is_mem & (size_b ? 1'b0 : (size_h ? lane[0] : (lane != 2'b00)));
`else
      misaligned = 1'b0;
`endif
   end

   always_comb begin
      dmem_addr_o = {ex_mem_i.alu_result[31:2], 2'b00};
      dmem_we_o   = ex_mem_i.mem_write_en;
      if (size_b) begin
         dmem_be_o    = 4'b0001 << lane;
         dmem_wdata_o = {4{ex_mem_i.mem_store_value[7:0]}};
      end else if (size_h) begin
         dmem_be_o    = 4'b0011 << {lane[1], 1'b0};
         dmem_wdata_o = {2{ex_mem_i.mem_store_value[15:0]}};
      end else begin
         dmem_be_o    = 4'b1111;
         dmem_wdata_o = ex_mem_i.mem_store_value;
      end
   end

   always_comb begin
      case (lane)
         2'd0:    ld_byte = dmem_rdata_i[7:0];
         2'd1:    ld_byte = dmem_rdata_i[15:8];
         2'd2:    ld_byte = dmem_rdata_i[23:16];
         default: ld_byte = dmem_rdata_i[31:24];
      endcase
      ld_half = lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (funct3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = dmem_rdata_i;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      req      = 1'b0;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_mem & ~misaligned) begin
               req = 1'b1;
               if (dmem_ready_i) begin
                  if (is_store) complete = 1'b1;
                  else          state_d  = ST_RESP;
               end else begin
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            req = 1'b1;
            if (dmem_ready_i) begin
               if (ex_mem_i.mem_write_en) begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (dmem_rvalid_i) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_wb_d = MEM_WB_BUBBLE;
      if (ex_mem_valid_i & ~misaligned & (~is_mem | complete)) begin
         mem_wb_d.instruction     = ex_mem_i.instruction;
         mem_wb_d.rd              = ex_mem_i.rd;
         mem_wb_d.regFile_we      = ex_mem_i.regFile_we & ~is_store;
         mem_wb_d.reg_store_value = is_load ? ld_ext : ex_mem_i.alu_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mem_wb_q <= MEM_WB_BUBBLE;
      end else begin
         state_q  <= state_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   // Request/stall are combinational from ex_mem_i, so they are masked while reset is held.
   always_comb begin
      mem_wb_o   = mem_wb_q;
      dmem_req_o = ~rst & req;
      stall_o    = ~rst & is_mem & ~misaligned & ~complete;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      misalign_o = ~rst & misaligned;
`else
      misalign_o = 1'b0;
`endif
   end

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Directed bench for rv32_mem_stage; expected values are hand-computed constants.
module tb_rv32_mem_stage;
   import rv32_pipeline_pkg::*;

   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_STORE = 7'h23;
   localparam logic [6:0] OP_ALU   = 7'h33;

   logic        clk = 1'b0;
   logic        rst;
   ex_mem_t     ex_mem;
   logic        ex_valid;
   logic        stall;
   mem_wb_t     mem_wb;
   logic        req, we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ready, rvalid;
   logic [31:0] rdata;
   logic        misalign;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   rv32_mem_stage dut (
      .clk(clk), .rst(rst),
      .ex_mem_i(ex_mem), .ex_mem_valid_i(ex_valid),
      .stall_o(stall), .mem_wb_o(mem_wb),
      .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr),
      .dmem_be_o(be), .dmem_wdata_o(wdata),
      .dmem_ready_i(ready), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
      .misalign_o(misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] op);
      return {17'h0, f3, 5'h0, op};
   endfunction

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] sv, input logic [4:0] rd, input logic rfwe,
                        input logic re, input logic wre);
      ex_valid               = v;
      ex_mem.instruction     = ins;
      ex_mem.alu_result      = alu;
      ex_mem.mem_store_value = sv;
      ex_mem.rd              = rd;
      ex_mem.regFile_we      = rfwe;
      ex_mem.mem_read_en     = re;
      ex_mem.mem_write_en    = wre;
   endtask

   task automatic bubble;
      drive(1'b0, 32'h0000_0013, '0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".instr"}, mem_wb.instruction, 32'h0000_0013);
      check({tag, ".rd"}, 32'(mem_wb.rd), 32'd0);
      check({tag, ".we"}, 32'(mem_wb.regFile_we), 32'd0);
      check({tag, ".rsv"}, mem_wb.reg_store_value, 32'd0);
   endtask

   // wait_cycles = number of cycles ready is held low before acceptance.
   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sv, input int unsigned wait_cycles,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata);
      drive(1'b1, mk_instr(f3, OP_STORE), a, sv, 5'd9, 1'b1, 1'b0, 1'b1);
      ready = (wait_cycles == 0);
      #1;
      check({tag, ".req"}, 32'(req), 32'd1);
      check({tag, ".we"}, 32'(we), 32'd1);
      check({tag, ".addr"}, addr, exp_addr);
      check({tag, ".be"}, 32'(be), 32'(exp_be));
      check({tag, ".wdata"}, wdata, exp_wdata);
      check({tag, ".stall0"}, 32'(stall), (wait_cycles == 0) ? 32'd0 : 32'd1);
      for (int unsigned i = 0; i < wait_cycles; i++) begin
         tick;
         ready = (i + 1 == wait_cycles);
         #1;
         check({tag, ".stall_w"}, 32'(stall), (i + 1 == wait_cycles) ? 32'd0 : 32'd1);
         check({tag, ".req_held"}, 32'(req), 32'd1);
         check({tag, ".be_held"}, 32'(be), 32'(exp_be));
         check({tag, ".wb_stalled"}, mem_wb.instruction, 32'h0000_0013);
      end
      tick;
      ready = 1'b0;
      check({tag, ".wb_we"}, 32'(mem_wb.regFile_we), 32'd0);
      check({tag, ".wb_rsv"}, mem_wb.reg_store_value, a);
      check({tag, ".wb_instr"}, mem_wb.instruction, mk_instr(f3, OP_STORE));
   endtask

   // Accepted immediately; rvalid arrives rv_delay cycles after acceptance.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input int unsigned rv_delay, input logic [31:0] rd_data,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp);
      drive(1'b1, mk_instr(f3, OP_LOAD), a, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b1, 1'b0);
      ready  = 1'b1;
      rvalid = 1'b0;
      #1;
      check({tag, ".req"}, 32'(req), 32'd1);
      check({tag, ".we"}, 32'(we), 32'd0);
      check({tag, ".addr"}, addr, exp_addr);
      check({tag, ".be"}, 32'(be), 32'(exp_be));
      check({tag, ".stall_acc"}, 32'(stall), 32'd1);
      tick;
      ready = 1'b0;
      for (int unsigned i = 1; i < rv_delay; i++) begin
         #1;
         check({tag, ".stall_resp"}, 32'(stall), 32'd1);
         check({tag, ".req_resp"}, 32'(req), 32'd0);
         tick;
      end
      rvalid = 1'b1;
      rdata  = rd_data;
      #1;
      check({tag, ".stall_done"}, 32'(stall), 32'd0);
      tick;
      rvalid = 1'b0;
      rdata  = 32'h5A5A_5A5A;
      check({tag, ".rsv"}, mem_wb.reg_store_value, exp);
      check({tag, ".rd"}, 32'(mem_wb.rd), 32'd7);
      check({tag, ".wb_we"}, 32'(mem_wb.regFile_we), 32'd1);
      check({tag, ".instr"}, mem_wb.instruction, mk_instr(f3, OP_LOAD));
   endtask

   initial begin
      rst    = 1'b1;
      ready  = 1'b0;
      rvalid = 1'b0;
      rdata  = '0;
      bubble();
      repeat (2) @(posedge clk);
      #1;
      check_bubble("rst");
      check("rst.stall", 32'(stall), 32'd0);
      check("rst.req", 32'(req), 32'd0);
      check("rst.misalign", 32'(misalign), 32'd0);
      drive(1'b1, mk_instr(3'b010, OP_STORE), 32'h40, 32'h1, 5'd1, 1'b0, 1'b0, 1'b1);
      #1;
      check("rst.req_masked", 32'(req), 32'd0);
      check("rst.stall_masked", 32'(stall), 32'd0);
      bubble();
      rst = 1'b0;
      tick;

      // Non-memory pass-through
      drive(1'b1, mk_instr(3'b000, OP_ALU), 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
      #1;
      check("add.stall", 32'(stall), 32'd0);
      check("add.req", 32'(req), 32'd0);
      tick;
      check("add.rsv", mem_wb.reg_store_value, 32'h1234);
      check("add.rd", 32'(mem_wb.rd), 32'd5);
      check("add.we", 32'(mem_wb.regFile_we), 32'd1);
      check("add.stall_after", 32'(stall), 32'd0);
      bubble();
      tick;
      check_bubble("bub");

      // Stores
      do_store("sb", 3'b000, 32'h103, 32'h0000_00AB, 2, 32'h100, 4'b1000, 32'hABAB_ABAB);
      do_store("sh", 3'b001, 32'h002, 32'h1234_5678, 1, 32'h000, 4'b1100, 32'h5678_5678);
      do_store("sw", 3'b010, 32'h040, 32'hCAFE_F00D, 0, 32'h040, 4'b1111, 32'hCAFE_F00D);
      bubble();
      tick;

      // Loads, back to back
      do_load("lb",  3'b000, 32'h101, 2, 32'h0000_8000, 32'h100, 4'b0010, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h101, 2, 32'h0000_8000, 32'h100, 4'b0010, 32'h0000_0080);
      do_load("lh",  3'b001, 32'h102, 1, 32'h8001_0000, 32'h100, 4'b1100, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h102, 1, 32'hBEEF_0000, 32'h100, 4'b1100, 32'h0000_BEEF);
      do_load("lw",  3'b010, 32'h200, 1, 32'hDEAD_BEEF, 32'h200, 4'b1111, 32'hDEAD_BEEF);
      bubble();
      tick;

      // Reset while waiting in RESP
      drive(1'b1, mk_instr(3'b010, OP_LOAD), 32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
      ready = 1'b1;
      tick;
      ready = 1'b0;
      #1;
      check("rresp.stall", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      check_bubble("rresp.async");
      check("rresp.stall_rst", 32'(stall), 32'd0);
      tick;
      rst = 1'b0;
      // Stale rvalid must neither complete a fresh load in IDLE nor in REQ
      drive(1'b1, mk_instr(3'b010, OP_LOAD), 32'h304, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
      rvalid = 1'b1;
      rdata  = 32'h1234_5678;
      #1;
      check("stale.req_idle", 32'(req), 32'd1);
      check("stale.stall_idle", 32'(stall), 32'd1);
      tick;
      check_bubble("stale.wb");
      check("stale.stall_req", 32'(stall), 32'd1);
      check("stale.req_req", 32'(req), 32'd1);
      rvalid = 1'b0;
      ready  = 1'b1;
      tick;
      ready  = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'h1122_3344;
      #1;
      check("stale.stall_done", 32'(stall), 32'd0);
      tick;
      rvalid = 1'b0;
      check("stale.rsv", mem_wb.reg_store_value, 32'h1122_3344);
      check("stale.rd", 32'(mem_wb.rd), 32'd4);
      bubble();
      tick;

      // Misaligned word access
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      drive(1'b1, mk_instr(3'b010, OP_LOAD), 32'h102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
      ready = 1'b1;
      #1;
      check("mis.req", 32'(req), 32'd0);
      check("mis.pulse", 32'(misalign), 32'd1);
      check("mis.stall", 32'(stall), 32'd0);
      tick;
      ready = 1'b0;
      check_bubble("mis.wb");
      bubble();
      #1;
      check("mis.pulse_end", 32'(misalign), 32'd0);
`else
      do_load("lw_unal", 3'b010, 32'h102, 1, 32'h0BAD_F00D, 32'h100, 4'b1111, 32'h0BAD_F00D);
      check("lw_unal.misalign", 32'(misalign), 32'd0);
      bubble();
`endif
      tick;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
